// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller slice.
package pipeline_pkg;

    // Width of an architectural register index (x0..x31).
    localparam int REG_IDX_W = 5;

    // Hazard controller FSM states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side inputs and controller outputs for the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipeline_pkg::*;

    logic [REG_IDX_W-1:0] rs1_D;
    logic [REG_IDX_W-1:0] rs2_D;
    logic                 MemReadE;
    logic [REG_IDX_W-1:0] RdE;
    logic                 BranchM;
    logic                 ZeroM;
    logic                 MemReadM;
    logic                 MemWriteM;
    logic                 dmem_ready;

    logic                 dmem_req;
    logic                 PCWrite;
    logic                 PCSrc;
    logic                 IF_ID_Write;
    logic                 ID_EX_Write;
    logic                 EX_MEM_Write;
    logic                 IF_ID_Flush;
    logic                 ID_EX_Flush;
    logic                 EX_MEM_Flush;
    logic                 MEM_WB_Bubble;
    logic                 mem_err;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    // Pipeline / datapath side: presents hazard sources, consumes controls.
    modport master (
        output rs1_D, rs2_D, MemReadE, RdE, BranchM, ZeroM,
               MemReadM, MemWriteM, dmem_ready,
        input  dmem_req, PCWrite, PCSrc, IF_ID_Write, ID_EX_Write,
               EX_MEM_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
               MEM_WB_Bubble, mem_err, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  rs1_D, rs2_D, MemReadE, RdE, BranchM, ZeroM,
               MemReadM, MemWriteM, dmem_ready,
        output dmem_req, PCWrite, PCSrc, IF_ID_Write, ID_EX_Write,
               EX_MEM_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush,
               MEM_WB_Bubble, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1_D,
    input  logic [REG_IDX_W-1:0] rs2_D,
    input  logic [REG_IDX_W-1:0] RdE,
    input  logic                 MemReadE,
    output logic                 load_use
);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = MemReadE & (RdE != '0) & ((RdE == rs1_D) | (RdE == rs2_D));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use bubbles, branch flushes, memory freeze
// with timeout-to-error, plus stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e           state;
    logic [7:0]       wait_cnt;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic mem_acc;
    logic freeze;
    logic branch_taken;
    logic load_use;

    logic dmem_req;
    logic pc_write;
    logic pc_src;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_bubble;

    hazard_detect u_hazard_detect (
        .rs1_D    (bus.rs1_D),
        .rs2_D    (bus.rs2_D),
        .RdE      (bus.RdE),
        .MemReadE (bus.MemReadE),
        .load_use (load_use)
    );

    assign mem_acc      = bus.MemReadM | bus.MemWriteM;
    assign freeze       = (mem_acc & ~bus.dmem_ready) | (state == ERROR);
    assign branch_taken = bus.BranchM & bus.ZeroM & ~freeze;

    // Memory-wait FSM: RUN -> MEM_WAIT on an unready access, ERROR on timeout (sticky).
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_acc & ~bus.dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= ERROR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= RUN;
            endcase
        end
    end

    // Priority mux: reset, then freeze, then taken branch, then load-use bubble.
    always_comb begin
        dmem_req      = mem_acc & (state != ERROR) & ~reset;
        pc_write      = 1'b1;
        pc_src        = 1'b0;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            // Hold the front end and drain NOPs into every stage while in reset.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (freeze) begin
            // EX/MEM is held, so a branch in MEM resolves once the access completes.
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            pc_src        = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
        end else if (load_use) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_flush   = 1'b1;
        end
    end

    // Performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_write) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_taken) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.dmem_req      = dmem_req;
    assign bus.PCWrite       = pc_write;
    assign bus.PCSrc         = pc_src;
    assign bus.IF_ID_Write   = if_id_write;
    assign bus.ID_EX_Write   = id_ex_write;
    assign bus.EX_MEM_Write  = ex_mem_write;
    assign bus.IF_ID_Flush   = if_id_flush;
    assign bus.ID_EX_Flush   = id_ex_flush;
    assign bus.EX_MEM_Flush  = ex_mem_flush;
    assign bus.MEM_WB_Bubble = mem_wb_bubble;
    assign bus.mem_err       = mem_err;
    assign bus.stall_cnt     = stall_cnt;
    assign bus.flush_cnt     = flush_cnt;

endmodule
